// File: rtl/credit_tx.sv
// credit_tx: transmit side of a credit-based link.
//
// Upstream words are accepted into a 2-entry skid buffer and forwarded onto a
// registered, ready-less link. A word is only issued while the remote FIFO has
// free space, as tracked by a credit counter. The receiver returns one credit
// pulse per dequeued entry.
//
// Handshake semantics (upstream side): a word transfers at a rising edge when
// valid_i and ready_o are both high. ready_o is derived from registered
// occupancy only, so it never depends on valid_i. Once valid_i is raised, the
// producer keeps it and data_i stable until the transfer happens. The link side
// has no ready: every cycle with valid_o high is one write into the remote FIFO.
//
// Ports:
//   clk_i       sole clock, rising edge
//   reset_ni    asynchronous active-low reset
//   data_i      upstream word
//   valid_i     upstream word valid
//   ready_o     skid buffer can accept a word this cycle (0 while in reset)
//   valid_o     link word valid (registered)
//   data_o      link word (registered, holds when idle)
//   credit_i    one returned credit per high cycle
//   credits_o   current credit count, 0..MaxCredits
//   overflow_o  sticky: credit returned while the counter was already full
module credit_tx #(
  parameter int DataWidth      = 8,
  parameter int NumCreditsLog2 = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic [DataWidth-1:0]    data_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic                    valid_o,
  output logic [DataWidth-1:0]    data_o,
  input  logic                    credit_i,
  output logic [NumCreditsLog2:0] credits_o,
  output logic                    overflow_o
);

  localparam int CW = NumCreditsLog2 + 1;
  localparam logic [CW-1:0] MaxCredits = CW'(1) << NumCreditsLog2;

  // Skid buffer storage and bookkeeping
  logic [DataWidth-1:0] mem_q [2];
  logic                 wr_ptr_q;
  logic                 rd_ptr_q;
  logic [1:0]           occ_q;
  logic [1:0]           occ_n;

  // Credit counter and link registers
  logic [CW-1:0]        credits_q;
  logic [CW-1:0]        credits_n;
  logic                 ovf_set;
  logic                 overflow_q;
  logic                 valid_q;
  logic [DataWidth-1:0] data_q;

  logic accept;
  logic send;

  // ready_o is gated by reset_ni so it reads 0 for the whole reset window.
  assign ready_o = (occ_q < 2'd2) & reset_ni;
  assign accept  = valid_i & ready_o;
  // Only the registered credit count enables a send. A credit arriving in
  // this cycle becomes usable one cycle later.
  assign send    = (occ_q != 2'd0) & (credits_q != '0);

  always_comb begin
    occ_n = occ_q;
    unique case ({accept, send})
      2'b10:   occ_n = occ_q + 2'd1;
      2'b01:   occ_n = occ_q - 2'd1;
      default: occ_n = occ_q;
    endcase
  end

  // A send and a returned credit in the same edge cancel out. A lone credit at
  // full count saturates and flags overflow instead of wrapping.
  always_comb begin
    credits_n = credits_q;
    ovf_set   = 1'b0;
    if (send && !credit_i) begin
      credits_n = credits_q - CW'(1);
    end else if (!send && credit_i) begin
      if (credits_q == MaxCredits) begin
        ovf_set = 1'b1;
      end else begin
        credits_n = credits_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      credits_q  <= MaxCredits;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      // With one entry held, an accept and a pop in the same edge touch
      // different slots, so the new word lands behind the remaining one.
      if (accept) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (send) begin
        rd_ptr_q <= ~rd_ptr_q;
        data_q   <= mem_q[rd_ptr_q];
      end
      valid_q    <= send;
      occ_q      <= occ_n;
      credits_q  <= credits_n;
      overflow_q <= overflow_q | ovf_set;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign credits_o  = credits_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_credit_tx.sv
// tb_credit_tx: directed and randomized bench for credit_tx.
// The instance uses NumCreditsLog2=2, so the counter holds at most 4 credits.
// The reference model keeps the skid buffer as a queue of words and the
// credit count as an integer. exp_q holds the words accepted but not yet
// observed on the link, and is checked in order.
module tb_credit_tx;
  localparam int DW   = 8;
  localparam int NL   = 2;
  localparam int MAXC = 1 << NL;

  logic          clk_i = 1'b0;
  logic          reset_ni;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic          ready_o;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic          credit_i;
  logic [NL:0]   credits_o;
  logic          overflow_o;

  credit_tx #(.DataWidth(DW), .NumCreditsLog2(NL)) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .credit_i   (credit_i),
    .credits_o  (credits_o),
    .overflow_o (overflow_o)
  );

  // Clock and reset
  always #5 clk_i = ~clk_i;

  // Reference model state
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] exp_q[$];
  int            m_cred;
  bit            m_ovf;
  bit            m_valid;
  logic [DW-1:0] m_data;
  bit            last_acc;
  int            link_count;

  int vectors;
  int miscompares;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_cred  = MAXC;
    m_ovf   = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
  endtask

  task automatic check_all();
    check("valid_o", {31'd0, valid_o}, {31'd0, m_valid});
    check("data_o", {24'd0, data_o}, {24'd0, m_data});
    check("ready_o", {31'd0, ready_o}, {31'd0, (reset_ni === 1'b1) && (m_q.size() < 2)});
    check("credits_o", {29'd0, credits_o}, m_cred);
    check("overflow_o", {31'd0, overflow_o}, {31'd0, m_ovf});
    if (valid_o === 1'b1) begin
      link_count++;
      if (exp_q.size() == 0) check("sb_spurious", {31'd0, valid_o}, 32'd0);
      else check("sb_order", {24'd0, data_o}, {24'd0, exp_q.pop_front()});
    end
  endtask

  // Driver: apply inputs, advance one edge, update the model, sample at +1.
  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit c);
    bit acc = 1'b0;
    bit snd = 1'b0;
    valid_i  = v;
    data_i   = d;
    credit_i = c;
    @(posedge clk_i);
    if (reset_ni === 1'b1) begin
      acc     = v && (m_q.size() < 2);
      snd     = (m_q.size() != 0) && (m_cred != 0);
      m_valid = snd;
      if (snd) m_data = m_q.pop_front();
      if (acc) begin
        m_q.push_back(d);
        exp_q.push_back(d);
      end
      m_cred = m_cred - int'(snd) + int'(c);
      if (m_cred > MAXC) begin
        m_cred = MAXC;
        m_ovf  = 1'b1;
      end
    end
    last_acc = acc;
    #1;
    check_all();
  endtask

  // Called 1 time unit after an edge; asserts reset between edges.
  task automatic async_reset();
    #2 reset_ni = 1'b0;
    #1;
    model_reset();
    check_all();
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_ready", {31'd0, ready_o}, 32'd0);
    check("rst_credits", {29'd0, credits_o}, MAXC);
    check("rst_overflow", {31'd0, overflow_o}, 32'd0);
  endtask

  task automatic release_reset();
    #1 reset_ni = 1'b1;
    #1;
    check("ready_after_release", {31'd0, ready_o}, 32'd1);
  endtask

  logic [DW-1:0] stream [4];
  logic [DW-1:0] w [6];

  initial begin
    vectors     = 0;
    miscompares = 0;
    link_count  = 0;
    last_acc    = 1'b0;
    reset_ni    = 1'b0;
    valid_i     = 1'b0;
    data_i      = '0;
    credit_i    = 1'b0;
    model_reset();

    // Reset values under random inputs
    for (int i = 0; i < 3; i++) begin
      cycle(1'($urandom), 8'($urandom), 1'($urandom));
      check("rst_data", {24'd0, data_o}, 32'd0);
      check("rst_credits", {29'd0, credits_o}, 32'd4);
      check("rst_ready", {31'd0, ready_o}, 32'd0);
    end
    release_reset();

    // Streaming 0x11..0x44 with no credit returns
    stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33; stream[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, stream[i], 1'b0);
      if (i >= 1) begin
        check("stream_valid", {31'd0, valid_o}, 32'd1);
        check("stream_data", {24'd0, data_o}, {24'd0, stream[i-1]});
        check("stream_credits", {29'd0, credits_o}, 4 - i);
      end else begin
        check("stream_first_idle", {31'd0, valid_o}, 32'd0);
      end
    end

    // Exhaustion and backpressure
    cycle(1'b1, 8'h55, 1'b0);
    check("last_stream_data", {24'd0, data_o}, 32'h44);
    check("credits_zero", {29'd0, credits_o}, 32'd0);
    cycle(1'b1, 8'h66, 1'b0);
    check("full_valid_low", {31'd0, valid_o}, 32'd0);
    check("full_ready_low", {31'd0, ready_o}, 32'd0);
    cycle(1'b1, 8'h77, 1'b0);
    check("held_ready_low", {31'd0, ready_o}, 32'd0);
    cycle(1'b1, 8'h77, 1'b1);
    check("credit_back", {29'd0, credits_o}, 32'd1);
    check("no_send_same_cycle", {31'd0, valid_o}, 32'd0);
    cycle(1'b1, 8'h77, 1'b0);
    check("resume_valid", {31'd0, valid_o}, 32'd1);
    check("resume_data", {24'd0, data_o}, 32'h55);
    check("resume_ready", {31'd0, ready_o}, 32'd1);
    begin
      int budget = 5;
      last_acc = 1'b0;
      while (!last_acc && budget > 0) begin
        cycle(1'b1, 8'h77, 1'b0);
        budget--;
      end
      check("accept_77_budget", {31'd0, last_acc}, 32'd1);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, m_cred < MAXC);
    check("drain_after_exhaust", exp_q.size(), 32'd0);

    // Send and credit return on the same edge
    async_reset();
    release_reset();
    for (int i = 0; i < 3; i++) w[i] = 8'($urandom);
    for (int i = 0; i < 3; i++) cycle(1'b1, w[i], 1'b0);
    check("pre_simul_credits", {29'd0, credits_o}, 32'd2);
    cycle(1'b0, 8'h00, 1'b1);
    check("simul_credits", {29'd0, credits_o}, 32'd2);
    check("simul_valid", {31'd0, valid_o}, 32'd1);
    check("simul_data", {24'd0, data_o}, {24'd0, w[2]});

    // Overflow from idle
    async_reset();
    release_reset();
    cycle(1'b0, 8'h00, 1'b0);
    check("idle_credits", {29'd0, credits_o}, 32'd4);
    cycle(1'b0, 8'h00, 1'b1);
    check("ovf_credits", {29'd0, credits_o}, 32'd4);
    check("ovf_set", {31'd0, overflow_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b0);
      check("ovf_sticky", {31'd0, overflow_o}, 32'd1);
    end
    async_reset();
    check("ovf_cleared", {31'd0, overflow_o}, 32'd0);
    release_reset();

    // Reset with two words buffered and one credit left
    for (int i = 0; i < 6; i++) w[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) cycle(1'b1, w[i], 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    check("mid_credits", {29'd0, credits_o}, 32'd1);
    check("mid_full", {31'd0, ready_o}, 32'd0);
    async_reset();
    release_reset();
    link_count = 0;
    cycle(1'b1, 8'hA0, 1'b0);
    cycle(1'b1, 8'hA1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0);
    check("post_reset_link_count", link_count, 32'd2);
    check("post_reset_drained", exp_q.size(), 32'd0);

    // Randomized traffic with a well-behaved receiver
    async_reset();
    release_reset();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 8'($urandom),
            (m_cred < MAXC) && ($urandom_range(0, 2) == 0));
    end
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      cycle(1'b0, 8'h00, m_cred < MAXC);
    end
    check("random_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
